// File: rtl/video_axis_bridge_if.sv
// AXI4-Stream video beat bundle: pixel data plus start-of-frame (tuser) and end-of-line (tlast).
interface video_axis_bridge_if #(
   parameter int unsigned P_DATA_W = 24
);
   logic [P_DATA_W-1:0] tdata;
   logic                tvalid;
   logic                tready;
   logic                tuser;
   logic                tlast;

   modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/video_axis_bridge.sv
// Turns the recovered parallel pixel stream into AXI4-Stream video through a FWFT FIFO,
// and measures line/frame geometry on the way.
module video_axis_bridge #(
   parameter int unsigned P_FIFO_DEPTH = 1024,
   parameter int unsigned P_DATA_W     = 24
) (
   input  logic                i_video_clk,
   input  logic                i_rst_n,
   input  logic                i_video_vsync,
   input  logic                i_video_hsync,
   input  logic                i_video_de,
   input  logic [P_DATA_W-1:0] i_video_data,
   video_axis_bridge_if.master m_axis,
   output logic [11:0]         o_line_pixels,
   output logic [11:0]         o_frame_lines,
   output logic                o_geom_valid,
   output logic [15:0]         o_frame_cnt,
   output logic                o_overflow
);

   localparam int unsigned AW = $clog2(P_FIFO_DEPTH);
   localparam int unsigned EW = P_DATA_W + 2;
   localparam logic [AW:0] FullCnt = P_FIFO_DEPTH[AW:0];

   typedef enum logic [1:0] {StWaitVs, StWaitDe, StActive, StDrop} state_e;

   logic                unused_hsync;
   logic                s1_vs_q, s1_de_q, s1_vs_prev_q, s1_de_prev_q;
   logic [P_DATA_W-1:0] s1_data_q;
   logic                vs_rise, de_fall;

   state_e              state_q;
   logic                hold_vld_q, hold_sof_q;
   logic [P_DATA_W-1:0] hold_data_q;
   logic                overflow_q;

   logic                wr_req, wr_ok, push, pop, full, load_out;
   logic [EW-1:0]       wr_data;
   logic [EW-1:0]       mem [P_FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [AW:0]         mem_cnt_q;
   logic                out_vld_q;
   logic [EW-1:0]       out_q;

   logic [11:0]         pix_cnt_q, line_cnt_q, line_cnt_inc;
   logic [11:0]         line_pixels_q, frame_lines_q;
   logic                geom_valid_q, vs_seen_q;
   logic [15:0]         frame_cnt_q;

   // Framing is driven purely by de; hsync carries no information we need.
   assign unused_hsync = i_video_hsync;

   always_ff @(posedge i_video_clk) begin
      if (!i_rst_n) begin
         s1_vs_q      <= 1'b0;
         s1_de_q      <= 1'b0;
         s1_data_q    <= '0;
         s1_vs_prev_q <= 1'b0;
         s1_de_prev_q <= 1'b0;
      end else begin
         s1_vs_q      <= i_video_vsync;
         s1_de_q      <= i_video_de;
         s1_data_q    <= i_video_data;
         s1_vs_prev_q <= s1_vs_q;
         s1_de_prev_q <= s1_de_q;
      end
   end

   assign vs_rise = s1_vs_q & ~s1_vs_prev_q;
   assign de_fall = s1_de_prev_q & ~s1_de_q;

   // The held pixel is only known to end a line once the next s1 sample arrives.
   always_comb begin
      wr_req  = hold_vld_q & (vs_rise | s1_de_q | de_fall);
      wr_data = {hold_sof_q, vs_rise | ~s1_de_q, hold_data_q};
   end

   always_ff @(posedge i_video_clk) begin
      if (!i_rst_n) begin
         state_q     <= StWaitVs;
         hold_vld_q  <= 1'b0;
         hold_sof_q  <= 1'b0;
         hold_data_q <= '0;
         overflow_q  <= 1'b0;
      end else begin
         if (wr_req && !wr_ok) overflow_q <= 1'b1;
         unique case (state_q)
            StWaitVs: begin
               if (vs_rise) state_q <= StWaitDe;
            end
            StWaitDe: begin
               if (s1_de_q) begin
                  hold_data_q <= s1_data_q;
                  hold_sof_q  <= 1'b1;
                  hold_vld_q  <= 1'b1;
                  state_q     <= StActive;
               end
            end
            StActive: begin
               if (vs_rise) begin
                  hold_vld_q <= 1'b0;
                  state_q    <= StWaitDe;
               end else if (wr_req && !wr_ok) begin
                  hold_vld_q <= 1'b0;
                  state_q    <= StDrop;
               end else if (s1_de_q) begin
                  hold_data_q <= s1_data_q;
                  hold_sof_q  <= 1'b0;
                  hold_vld_q  <= 1'b1;
               end else if (de_fall) begin
                  hold_vld_q <= 1'b0;
               end
            end
            StDrop: begin
               if (vs_rise) state_q <= StWaitDe;
            end
            default: state_q <= StWaitVs;
         endcase
      end
   end

   // Occupancy includes the output register; a pop frees a slot in the same cycle.
   assign pop      = out_vld_q & m_axis.tready;
   assign full     = (mem_cnt_q + {{AW{1'b0}}, out_vld_q}) == FullCnt;
   assign wr_ok    = ~full | pop;
   assign push     = wr_req & wr_ok;
   assign load_out = (~out_vld_q | pop) & (mem_cnt_q != '0);

   always_ff @(posedge i_video_clk) begin
      if (push) mem[wr_ptr_q] <= wr_data;
   end

   always_ff @(posedge i_video_clk) begin
      if (!i_rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         mem_cnt_q <= '0;
         out_vld_q <= 1'b0;
         out_q     <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (load_out) begin
            rd_ptr_q  <= rd_ptr_q + AW'(1);
            out_q     <= mem[rd_ptr_q];
            out_vld_q <= 1'b1;
         end else if (pop) begin
            out_vld_q <= 1'b0;
         end
         case ({push, load_out})
            2'b10:   mem_cnt_q <= mem_cnt_q + (AW + 1)'(1);
            2'b01:   mem_cnt_q <= mem_cnt_q - (AW + 1)'(1);
            default: mem_cnt_q <= mem_cnt_q;
         endcase
      end
   end

   assign m_axis.tvalid = out_vld_q;
   assign m_axis.tuser  = out_q[EW-1];
   assign m_axis.tlast  = out_q[EW-2];
   assign m_axis.tdata  = out_q[P_DATA_W-1:0];

   assign line_cnt_inc = (de_fall && line_cnt_q != 12'hFFF) ? line_cnt_q + 12'd1 : line_cnt_q;

   always_ff @(posedge i_video_clk) begin
      if (!i_rst_n) begin
         pix_cnt_q     <= '0;
         line_cnt_q    <= '0;
         line_pixels_q <= '0;
         frame_lines_q <= '0;
         geom_valid_q  <= 1'b0;
         vs_seen_q     <= 1'b0;
         frame_cnt_q   <= '0;
      end else begin
         if (s1_de_q) begin
            if (pix_cnt_q != 12'hFFF) pix_cnt_q <= pix_cnt_q + 12'd1;
         end else if (de_fall) begin
            line_pixels_q <= pix_cnt_q;
            pix_cnt_q     <= '0;
         end
         if (vs_rise) begin
            frame_lines_q <= line_cnt_inc;
            line_cnt_q    <= '0;
            frame_cnt_q   <= frame_cnt_q + 16'd1;
            vs_seen_q     <= 1'b1;
            if (vs_seen_q) geom_valid_q <= 1'b1;
         end else begin
            line_cnt_q <= line_cnt_inc;
         end
      end
   end

   assign o_line_pixels = line_pixels_q;
   assign o_frame_lines = frame_lines_q;
   assign o_geom_valid  = geom_valid_q;
   assign o_frame_cnt   = frame_cnt_q;
   assign o_overflow    = overflow_q;

endmodule

// File: tb/tb_video_axis_bridge.sv
// Scoreboard bench: a deep-FIFO and a 16-entry bridge share the video input; expected beats
// are queued per instance as pixels are driven and a negedge monitor pops and compares.
module tb_video_axis_bridge;

   localparam int unsigned DW = 24;
   localparam int Big = 32'h7fff_ffff;

   logic clk = 1'b0;
   logic rst_n, vs, hs, de;
   logic [DW-1:0] data;
   logic rdy_b, rdy_s, rnd_on, rnd_ready;

   video_axis_bridge_if #(.P_DATA_W(DW)) ax_b ();
   video_axis_bridge_if #(.P_DATA_W(DW)) ax_s ();

   logic [11:0] lp_b, fl_b, lp_s, fl_s;
   logic        gv_b, gv_s, ov_b, ov_s;
   logic [15:0] fc_b, fc_s;

   assign ax_b.tready = rnd_on ? rnd_ready : rdy_b;
   assign ax_s.tready = rdy_s;

   video_axis_bridge #(.P_FIFO_DEPTH(1024), .P_DATA_W(DW)) u_big (
      .i_video_clk(clk), .i_rst_n(rst_n), .i_video_vsync(vs), .i_video_hsync(hs),
      .i_video_de(de), .i_video_data(data), .m_axis(ax_b), .o_line_pixels(lp_b),
      .o_frame_lines(fl_b), .o_geom_valid(gv_b), .o_frame_cnt(fc_b), .o_overflow(ov_b)
   );

   video_axis_bridge #(.P_FIFO_DEPTH(16), .P_DATA_W(DW)) u_small (
      .i_video_clk(clk), .i_rst_n(rst_n), .i_video_vsync(vs), .i_video_hsync(hs),
      .i_video_de(de), .i_video_data(data), .m_axis(ax_s), .o_line_pixels(lp_s),
      .o_frame_lines(fl_s), .o_geom_valid(gv_s), .o_frame_cnt(fc_s), .o_overflow(ov_s)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int beats_b = 0, beats_s = 0, vcnt_b = 0, vcnt_s = 0;
   int lat_start = 0;
   logic lat_armed = 1'b0;
   logic stall_b = 1'b0, stall_s = 1'b0;
   logic [25:0] held_b, held_s;
   logic [25:0] exp_b[$];
   logic [25:0] exp_s[$];
   logic [DW-1:0] seq = 24'h000101;

   initial forever #5 clk = ~clk;
   initial forever begin @(posedge clk); cyc++; end
   initial forever begin @(posedge clk); #1; rnd_ready = 1'($urandom_range(0, 1)); end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   // Monitor: pops the scoreboards on accepted beats and checks stall stability.
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         stall_b = 1'b0;
         stall_s = 1'b0;
      end else begin
         if (ax_b.tvalid) vcnt_b++;
         if (ax_s.tvalid) vcnt_s++;
         if (stall_b) chk("big hold stable", 32'({ax_b.tvalid, ax_b.tuser, ax_b.tlast, ax_b.tdata}),
                          32'({1'b1, held_b}));
         if (stall_s) chk("small hold stable", 32'({ax_s.tvalid, ax_s.tuser, ax_s.tlast, ax_s.tdata}),
                          32'({1'b1, held_s}));
         if (lat_armed && ax_b.tvalid) begin
            chk("first tvalid latency", 32'(cyc), 32'(lat_start + 3));
            lat_armed = 1'b0;
         end
         if (ax_b.tvalid && ax_b.tready) begin
            beats_b++;
            if (exp_b.size() == 0) chk("big unexpected beat", 32'(exp_b.size()), 32'd1);
            else chk("big beat", 32'({ax_b.tuser, ax_b.tlast, ax_b.tdata}), 32'(exp_b.pop_front()));
         end
         if (ax_s.tvalid && ax_s.tready) begin
            beats_s++;
            if (exp_s.size() == 0) chk("small unexpected beat", 32'(exp_s.size()), 32'd1);
            else chk("small beat", 32'({ax_s.tuser, ax_s.tlast, ax_s.tdata}), 32'(exp_s.pop_front()));
         end
         stall_b = ax_b.tvalid && !ax_b.tready;
         stall_s = ax_s.tvalid && !ax_s.tready;
         held_b  = {ax_b.tuser, ax_b.tlast, ax_b.tdata};
         held_s  = {ax_s.tuser, ax_s.tlast, ax_s.tdata};
      end
   end

   task automatic step(input logic v, input logic d, input logic [DW-1:0] px);
      vs   = v;
      de   = d;
      hs   = ~d;
      data = px;
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut(input int n);
      rst_n = 1'b0;
      repeat (n) step(1'b0, 1'b0, '0);
      rst_n = 1'b1;
   endtask

   task automatic vs_pulse();
      step(1'b1, 1'b0, '0);
      step(1'b1, 1'b0, '0);
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b0, '0);
   endtask

   // keep: how many of this frame's pixels the small instance is expected to deliver.
   task automatic send_frame(input int w, input int h, input int keep, input logic arm);
      int ns;
      ns = 0;
      vs_pulse();
      for (int l = 0; l < h; l++) begin
         for (int p = 0; p < w; p++) begin
            logic [25:0] e;
            e = {(l == 0 && p == 0), (p == w - 1), seq};
            exp_b.push_back(e);
            if (ns < keep) exp_s.push_back(e);
            ns++;
            if (arm && l == 0 && p == 0) begin
               lat_start = cyc + 1;
               lat_armed = 1'b1;
            end
            step(1'b0, 1'b1, seq);
            seq = seq + 24'd1;
         end
         repeat (4) step(1'b0, 1'b0, '0);
      end
   endtask

   task automatic drain();
      int k;
      k = 0;
      while ((exp_b.size() != 0 || exp_s.size() != 0) && k < 4000) begin
         step(1'b0, 1'b0, '0);
         k++;
      end
      chk("drain complete", 32'(exp_b.size() + exp_s.size()), 32'd0);
      repeat (5) step(1'b0, 1'b0, '0);
   endtask

   initial begin
      rst_n  = 1'b0;
      rdy_b  = 1'b1;
      rdy_s  = 1'b1;
      rnd_on = 1'b0;
      vs = 1'b0; hs = 1'b1; de = 1'b0; data = '0;
      @(posedge clk); #1;

      // Reset values
      repeat (3) step(1'b0, 1'b1, 24'hABCDEF);
      chk("reset big axis", 32'({ax_b.tvalid, ax_b.tuser, ax_b.tlast, ax_b.tdata}), 32'd0);
      chk("reset small axis", 32'({ax_s.tvalid, ax_s.tuser, ax_s.tlast, ax_s.tdata}), 32'd0);
      chk("reset big status", 32'({lp_b, fl_b, gv_b, ov_b}), 32'd0);
      chk("reset frame cnt", 32'({fc_b, fc_s}), 32'd0);
      rst_n = 1'b1;

      // Startup: de activity with no vsync must not produce beats
      vcnt_b = 0; vcnt_s = 0;
      for (int l = 0; l < 2; l++) begin
         for (int p = 0; p < 6; p++) step(1'b0, 1'b1, 24'(p + 16));
         repeat (4) step(1'b0, 1'b0, '0);
      end
      repeat (6) step(1'b0, 1'b0, '0);
      chk("startup big tvalid cycles", 32'(vcnt_b), 32'd0);
      chk("startup small tvalid cycles", 32'(vcnt_s), 32'd0);

      // Basic framing 4x3
      send_frame(4, 3, Big, 1'b1);
      drain();
      chk("latency observed", 32'(lat_armed), 32'd0);

      // Geometry
      reset_dut(2);
      send_frame(8, 4, Big, 1'b0);
      chk("geom valid after 1st vs", 32'(gv_b), 32'd0);
      chk("frame cnt after 1st vs", 32'(fc_b), 32'd1);
      send_frame(8, 4, Big, 1'b0);
      chk("geom valid after 2nd vs", 32'(gv_b), 32'd1);
      vs_pulse();
      chk("line pixels", 32'(lp_b), 32'd8);
      chk("frame lines", 32'(fl_b), 32'd4);
      chk("frame cnt after 3rd vs", 32'(fc_b), 32'd3);
      chk("geom valid after 3rd vs", 32'(gv_b), 32'd1);
      drain();

      // Overflow on the 16-entry instance
      reset_dut(2);
      rdy_s = 1'b0;
      beats_s = 0;
      send_frame(8, 4, 16, 1'b0);
      repeat (20) step(1'b0, 1'b0, '0);
      chk("small overflow set", 32'(ov_s), 32'd1);
      chk("big overflow clear", 32'(ov_b), 32'd0);
      chk("small beats while stalled", 32'(beats_s), 32'd0);
      chk("small tvalid while full", 32'(ax_s.tvalid), 32'd1);
      rdy_s = 1'b1;
      drain();
      chk("small beats after release", 32'(beats_s), 32'd16);
      send_frame(8, 4, Big, 1'b0);
      drain();
      chk("small overflow sticky", 32'(ov_s), 32'd1);

      // Reset in the middle of line 2
      reset_dut(2);
      chk("overflow cleared by reset", 32'(ov_s), 32'd0);
      vs_pulse();
      for (int p = 0; p < 4; p++) begin
         exp_b.push_back({(p == 0), (p == 3), seq});
         exp_s.push_back({(p == 0), (p == 3), seq});
         step(1'b0, 1'b1, seq);
         seq = seq + 24'd1;
      end
      drain();
      step(1'b0, 1'b1, 24'h55AA55);
      rst_n = 1'b0;
      step(1'b0, 1'b1, 24'h55AA56);
      step(1'b0, 1'b1, 24'h55AA57);
      rst_n = 1'b1;
      vcnt_b = 0; vcnt_s = 0;
      step(1'b0, 1'b0, '0);
      for (int l = 0; l < 2; l++) begin
         for (int p = 0; p < 4; p++) step(1'b0, 1'b1, 24'(p + 32));
         repeat (4) step(1'b0, 1'b0, '0);
      end
      repeat (6) step(1'b0, 1'b0, '0);
      chk("post-reset big tvalid cycles", 32'(vcnt_b), 32'd0);
      chk("post-reset small tvalid cycles", 32'(vcnt_s), 32'd0);
      send_frame(4, 3, Big, 1'b0);
      drain();

      // Random backpressure on the deep instance
      beats_b = 0;
      rnd_on = 1'b1;
      for (int f = 0; f < 3; f++) send_frame(16, 8, Big, 1'b0);
      rnd_on = 1'b0;
      drain();
      chk("random beats delivered", 32'(beats_b), 32'd384);
      chk("random no overflow", 32'(ov_b), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
